seller: RTL and testbench
=========================

SELLER -- requirements
Module: seller

Interface
REQ-001 The clock and reset SHALL be `clk` and `reset`: one clock, with reset asynchronous and active-high.
REQ-002 The module SHALL have these ports:
- clk        input   1   system clock; all state updates on the rising edge
- reset      input   1   asynchronous, active-high; clears all state
- in_money   input   10  coin value currently presented (unsigned, 0 = no coin)
- choose     input   4   drink select: 4'd1=A, 4'd2=B, 4'd3=C, 4'd4=D; any other value means no selection
- notbuy     input   1   cancel request; refunds the full balance
- out_money  output  10  change or refund amount (registered)
- canbuy_A   output  1   balance >= price A
- canbuy_B   output  1   balance >= price B
- canbuy_C   output  1   balance >= price C
- canbuy_D   output  1   balance >= price D
- giveDrink  output  3   dispensed drink: 0 none, 1 A, 2 B, 3 C, 4 D (registered)
REQ-003 The prices SHALL be fixed parameters: PRICE_A=15, PRICE_B=20, PRICE_C=25, PRICE_D=30.

Function
REQ-004 The FSM SHALL have exactly three states: COLLECT (reset state), VEND, REFUND.
REQ-005 A 10-bit balance register SHALL be kept, along with a 10-bit register holding last cycle's in_money sample (prev_in).
REQ-006 In COLLECT, a coin SHALL be accepted at an edge when in_money != 0 and in_money != prev_in; on acceptance, balance <= balance + in_money, saturating at 1023.
REQ-007 prev_in SHALL update to in_money on every edge, in all states.
REQ-008 A constant nonzero in_money SHALL count once; a changed nonzero value SHALL count as a new coin.
REQ-009 canbuy_X SHALL be combinational compares of the registered balance against PRICE_X in COLLECT, and SHALL be 0 in VEND and REFUND.
REQ-010 Decisions in COLLECT SHALL use the balance registered before the current edge; a coin arriving on the same edge is not yet included.
REQ-011 In COLLECT with notbuy=1, the next state SHALL be REFUND: out_money <= balance, giveDrink <= 0, balance <= 0.
REQ-012 notbuy SHALL have priority over choose when both are asserted on the same edge.
REQ-013 In COLLECT with notbuy=0, a valid choose and balance >= its price, the next state SHALL be VEND: giveDrink <= code, out_money <= balance - price, balance <= 0.
REQ-014 A valid choose with insufficient balance SHALL be ignored: state remains COLLECT, outputs stay 0, coins keep accumulating.
REQ-015 Because choose is level-sensitive, a held choose SHALL vend on the first edge at which the balance suffices.
REQ-016 Invalid choose codes (0, 5-15) SHALL be ignored.
REQ-017 VEND and REFUND SHALL be terminal: outputs are held, and in_money, choose and notbuy are ignored until reset.
REQ-018 Latency SHALL be one clock: giveDrink and out_money are valid immediately after the edge that samples the qualifying choose or notbuy.
REQ-019 In COLLECT, giveDrink SHALL be 0 and out_money SHALL be 0.

Reset
REQ-020 While reset=1, regardless of clk, the block SHALL hold: state=COLLECT, balance=0, prev_in=0, out_money=0, giveDrink=0, and all canbuy_* = 0.
REQ-021 On reset deassertion, the first rising edge SHALL already accept coins; reset asserted mid-transaction SHALL discard the balance with no refund output.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- in_money=20 and choose=1 applied together -> 1st edge: balance 20, canbuy_A=1, canbuy_B=1; 2nd edge: giveDrink=1, out_money=5.
- in_money=25, choose=2 one cycle later -> giveDrink=2, out_money=5. Likewise 30/choose=3 -> giveDrink=3, out_money=5; 35/choose=4 -> giveDrink=4, out_money=5.
- in_money=5, choose=1 -> canbuy_A..D all 0, giveDrink stays 0, out_money stays 0, state COLLECT.
- in_money=20, then notbuy=1 together with choose=2 -> giveDrink=0, out_money=20 (refund wins).
- in_money=10 held 2 cycles, then 5, then choose=1 -> balance 15 (10 counted once), giveDrink=1, out_money=0.
- Reset pulse between scenarios -> all outputs 0 asynchronously; the next transaction starts from balance 0.

Source files
------------

// File: rtl/seller.sv
// seller: four-drink vending controller with coin edge detection, level-sensitive
// selection, cancel/refund and one-shot terminal VEND/REFUND states. Rev 1.0
`default_nettype none

module seller #(
  parameter logic [9:0] PRICE_A = 10'd15,
  parameter logic [9:0] PRICE_B = 10'd20,
  parameter logic [9:0] PRICE_C = 10'd25,
  parameter logic [9:0] PRICE_D = 10'd30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] in_money,
  input  logic [3:0] choose,
  input  logic       notbuy,
  output logic [9:0] out_money,
  output logic       canbuy_A,
  output logic       canbuy_B,
  output logic       canbuy_C,
  output logic       canbuy_D,
  output logic [2:0] giveDrink
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    REFUND  = 2'd2
  } state_t;

  state_t      r_state;
  logic [9:0]  r_balance;
  logic [9:0]  r_prev_in;
  logic [9:0]  r_out_money;
  logic [2:0]  r_give;

  logic        w_sel_valid;
  logic [9:0]  w_price;
  logic        w_afford;
  logic        w_coin;
  logic [10:0] w_sum;
  logic [9:0]  w_bal_next;
  logic        w_collect;

  always_comb begin
    w_sel_valid = 1'b0;
    w_price     = 10'd0;
    case (choose)
      4'd1: begin w_sel_valid = 1'b1; w_price = PRICE_A; end
      4'd2: begin w_sel_valid = 1'b1; w_price = PRICE_B; end
      4'd3: begin w_sel_valid = 1'b1; w_price = PRICE_C; end
      4'd4: begin w_sel_valid = 1'b1; w_price = PRICE_D; end
      default: begin w_sel_valid = 1'b0; w_price = 10'd0; end
    endcase
  end

  assign w_afford   = w_sel_valid && (r_balance >= w_price);
  // A coin is a nonzero value that differs from last cycle's sample.
  assign w_coin     = (in_money != 10'd0) && (in_money != r_prev_in);
  assign w_sum      = {1'b0, r_balance} + {1'b0, in_money};
  assign w_bal_next = w_sum[10] ? 10'd1023 : w_sum[9:0];
  assign w_collect  = (r_state == COLLECT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= COLLECT;
      r_balance   <= 10'd0;
      r_prev_in   <= 10'd0;
      r_out_money <= 10'd0;
      r_give      <= 3'd0;
    end else begin
      r_prev_in <= in_money;
      case (r_state)
        COLLECT: begin
          if (notbuy) begin
            r_state     <= REFUND;
            r_out_money <= r_balance;
            r_give      <= 3'd0;
            r_balance   <= 10'd0;
          end else if (w_afford) begin
            r_state     <= VEND;
            r_out_money <= r_balance - w_price;
            r_give      <= choose[2:0];
            r_balance   <= 10'd0;
          end else if (w_coin) begin
            r_balance   <= w_bal_next;
          end
        end
        VEND, REFUND: begin
          // Terminal until reset: hold outputs, ignore all inputs.
          r_state <= r_state;
        end
        default: begin
          r_state     <= COLLECT;
          r_balance   <= 10'd0;
          r_out_money <= 10'd0;
          r_give      <= 3'd0;
        end
      endcase
    end
  end

  assign out_money = r_out_money;
  assign giveDrink = r_give;
  assign canbuy_A  = w_collect && (r_balance >= PRICE_A);
  assign canbuy_B  = w_collect && (r_balance >= PRICE_B);
  assign canbuy_C  = w_collect && (r_balance >= PRICE_C);
  assign canbuy_D  = w_collect && (r_balance >= PRICE_D);

endmodule

`default_nettype wire

// File: tb/tb_seller.sv
// tb_seller: directed plus randomized checks of seller against a behavioural vending model.
`default_nettype none

module tb_seller;

  logic       clk;
  logic       reset;
  logic [9:0] in_money;
  logic [3:0] choose;
  logic       notbuy;
  logic [9:0] out_money;
  logic       canbuy_A, canbuy_B, canbuy_C, canbuy_D;
  logic [2:0] giveDrink;

  int tests = 0;
  int fails = 0;

  // Behavioural model: customer balance, last coin sample, finished flag, outputs.
  int m_bal, m_prev, m_out, m_give;
  bit m_done;

  seller dut (
    .clk(clk), .reset(reset), .in_money(in_money), .choose(choose), .notbuy(notbuy),
    .out_money(out_money), .canbuy_A(canbuy_A), .canbuy_B(canbuy_B),
    .canbuy_C(canbuy_C), .canbuy_D(canbuy_D), .giveDrink(giveDrink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int price_of(input int code);
    case (code)
      1: return 15;
      2: return 20;
      3: return 25;
      4: return 30;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_money"}, int'(out_money), m_out);
    chk({tag, ".giveDrink"}, int'(giveDrink), m_give);
    chk({tag, ".canbuy_A"}, int'(canbuy_A), int'(!m_done && m_bal >= 15));
    chk({tag, ".canbuy_B"}, int'(canbuy_B), int'(!m_done && m_bal >= 20));
    chk({tag, ".canbuy_C"}, int'(canbuy_C), int'(!m_done && m_bal >= 25));
    chk({tag, ".canbuy_D"}, int'(canbuy_D), int'(!m_done && m_bal >= 30));
  endtask

  task automatic model_reset();
    m_bal = 0; m_prev = 0; m_out = 0; m_give = 0; m_done = 0;
  endtask

  task automatic model_edge(input int money, input int ch, input bit nb);
    if (!m_done) begin
      if (nb) begin
        m_out = m_bal; m_give = 0; m_bal = 0; m_done = 1;
      end else if (price_of(ch) >= 0 && m_bal >= price_of(ch)) begin
        m_out = m_bal - price_of(ch); m_give = ch; m_bal = 0; m_done = 1;
      end else if (money != 0 && money != m_prev) begin
        m_bal = (m_bal + money > 1023) ? 1023 : m_bal + money;
      end
    end
    m_prev = money;
  endtask

  task automatic tick(input int money, input int ch, input bit nb, input string tag);
    @(negedge clk);
    in_money = 10'(money);
    choose   = 4'(ch);
    notbuy   = nb;
    @(posedge clk);
    model_edge(money, ch, nb);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse away from any clock edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    in_money = 10'd0; choose = 4'd0; notbuy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_money = 10'd0; choose = 4'd0; notbuy = 1'b0;
    model_reset();
    #1;
    check_all("reset_init");
    @(negedge clk);
    reset = 1'b0;

    // 20 with choose A together: coin counted first, vend on second edge.
    tick(20, 1, 0, "s1_e1");
    tick(20, 1, 0, "s1_e2");
    tick(0, 2, 0, "s1_terminal");
    pulse_reset("s1_reset");

    tick(25, 0, 0, "s2_coin");
    tick(25, 2, 0, "s2_vend");
    pulse_reset("s2_reset");
    tick(30, 0, 0, "s3_coin");
    tick(30, 3, 0, "s3_vend");
    pulse_reset("s3_reset");
    tick(35, 0, 0, "s4_coin");
    tick(35, 4, 0, "s4_vend");
    pulse_reset("s4_reset");

    // Insufficient balance: selection ignored.
    tick(5, 1, 0, "low_e1");
    tick(5, 1, 0, "low_e2");
    tick(0, 1, 0, "low_e3");
    pulse_reset("low_reset");

    // Cancel wins over a simultaneous affordable choice.
    tick(20, 0, 0, "ref_coin");
    tick(0, 2, 1, "ref_both");
    tick(40, 1, 0, "ref_terminal");
    pulse_reset("ref_reset");

    // Held coin counts once; changed value is a new coin.
    tick(10, 0, 0, "hold_e1");
    tick(10, 0, 0, "hold_e2");
    tick(5, 0, 0, "hold_e3");
    tick(5, 1, 0, "hold_vend");
    pulse_reset("hold_reset");

    // Reset mid-transaction discards balance without refund.
    tick(30, 0, 0, "mid_coin");
    pulse_reset("mid_reset");
    tick(0, 0, 1, "mid_refund_zero");
    pulse_reset("mid_reset2");

    // Saturation at 1023.
    tick(1000, 0, 0, "sat_e1");
    tick(999, 0, 0, "sat_e2");
    tick(1000, 0, 0, "sat_e3");
    tick(0, 0, 1, "sat_refund");
    pulse_reset("sat_reset");

    // Randomized sessions.
    for (int t = 0; t < 1500; t++) begin
      int money, ch;
      bit nb;
      money = ($urandom_range(0, 3) == 0) ? m_prev : 5 * $urandom_range(0, 8);
      ch    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 0;
      nb    = ($urandom_range(0, 24) == 0);
      tick(money, ch, nb, "rand");
      if (m_done && $urandom_range(0, 2) == 0) pulse_reset("rand_reset");
      else if ($urandom_range(0, 99) == 0) pulse_reset("rand_midreset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
